// File: rtl/sdram_arbiter_if.sv
// Generator-side bundle for the SDRAM arbiter: init/refresh/write/read command buses, requests and grants.
// Latency: none; wires only.
// Backpressure: a generator keeps its request level high until it sees its grant; ends are single-cycle pulses.
interface sdram_arbiter_if #(
    parameter int DQ_W   = 16,
    parameter int ADDR_W = 13
);
    // init stage
    logic [3:0]        init_cmd;
    logic [1:0]        init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;

    // auto-refresh stage
    logic              aref_req;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [1:0]        aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_en;

    // write stage
    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [1:0]        wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DQ_W-1:0]   wr_sdram_data;
    logic              wr_en;

    // read stage
    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [1:0]        rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DQ_W-1:0]   rd_sdram_data;

    // generator side
    modport master (
        output init_cmd, init_ba, init_addr, init_end,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  aref_en,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        input  wr_en,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  rd_en, rd_sdram_data
    );

    // arbiter side
    modport slave (
        input  init_cmd, init_ba, init_addr, init_end,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output aref_en,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        output wr_en,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output rd_en, rd_sdram_data
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Waits for SDRAM init, then grants refresh > write > read one at a time and muxes the owner onto the pins.
// Latency: grant one edge after the request is seen in ARBIT; command/bank/address mux is combinational.
// Backpressure: losers are not latched and must hold their request; grants drop only on the owner's end pulse.
module sdram_arbiter #(
    parameter int          DQ_W   = 16,
    parameter int          ADDR_W = 13,
    parameter logic [3:0]  NOP    = 4'b0111
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    sdram_arbiter_if.slave    gen,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DQ_W-1:0]   sdram_dq
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cmd_sel;
    logic [1:0]        ba_sel;
    logic [ADDR_W-1:0] addr_sel;

    // State register; reset drops straight back to INIT so the bus shows init_* immediately.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Clock enable is held low only while reset is asserted.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sdram_cke <= 1'b0;
        end else begin
            sdram_cke <= 1'b1;
        end
    end

    // Next state: every grant returns through ARBIT, so a busy owner's end is the only exit.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT: begin
                if (gen.init_end) state_nxt = ARBIT;
            end
            ARBIT: begin
                if (gen.aref_req)     state_nxt = AREF;
                else if (gen.wr_req)  state_nxt = WRITE;
                else if (gen.rd_req)  state_nxt = READ;
            end
            AREF: begin
                if (gen.aref_end) state_nxt = ARBIT;
            end
            WRITE: begin
                if (gen.wr_end) state_nxt = ARBIT;
            end
            READ: begin
                if (gen.rd_end) state_nxt = ARBIT;
            end
            default: state_nxt = ARBIT;
        endcase
    end

    // Pin mux: the current owner drives command/bank/address; idle arbitration parks on NOP.
    always_comb begin
        cmd_sel  = NOP;
        ba_sel   = 2'b11;
        addr_sel = {ADDR_W{1'b1}};
        case (state)
            INIT: begin
                cmd_sel  = gen.init_cmd;
                ba_sel   = gen.init_ba;
                addr_sel = gen.init_addr;
            end
            AREF: begin
                cmd_sel  = gen.aref_cmd;
                ba_sel   = gen.aref_ba;
                addr_sel = gen.aref_addr;
            end
            WRITE: begin
                cmd_sel  = gen.wr_cmd;
                ba_sel   = gen.wr_ba;
                addr_sel = gen.wr_addr;
            end
            READ: begin
                cmd_sel  = gen.rd_cmd;
                ba_sel   = gen.rd_ba;
                addr_sel = gen.rd_addr;
            end
            default: begin
                cmd_sel  = NOP;
                ba_sel   = 2'b11;
                addr_sel = {ADDR_W{1'b1}};
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
    assign sdram_ba   = ba_sel;
    assign sdram_addr = addr_sel;

    assign gen.aref_en = (state == AREF);
    assign gen.wr_en   = (state == WRITE);
    assign gen.rd_en   = (state == READ);

    // Only the write owner may drive DQ, and only while it presents data.
    assign sdram_dq          = (state == WRITE && gen.wr_sdram_en) ? gen.wr_sdram_data : {DQ_W{1'bz}};
    assign gen.rd_sdram_data = sdram_dq;

endmodule
